fp_adder: RTL and testbench

IEEE-754 single-precision floating-point adder for the FPU datapath. It accepts operands A and B over independent strobe/acknowledge input channels and computes A+B with round-to-nearest-even. It returns Z over a strobe/acknowledge output channel. It is a multi-cycle, one-operation-at-a-time sequencer: no pipelining, no parameters.

---
 rtl/fp_adder_pkg.sv | 28 ++
 rtl/fp_adder.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the single-precision adder: FSM states,
// exponent limits and the internal mantissa widths.
package fp_adder_pkg;

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL,
        ALIGN,
        ADD_0,
        ADD_1,
        NORM_1,
        NORM_2,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    localparam int MANT_W = 24;
    localparam int EXT_W  = 27;
    localparam int EXP_W  = 10;

    localparam logic signed [EXP_W-1:0] BIAS = 10'sd127;
    localparam logic signed [EXP_W-1:0] EMIN = -10'sd126;
    localparam logic [31:0]             QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, one operation at a time
// with strobe/acknowledge handshakes on both operands and the result.
module fp_adder
    import fp_adder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t state, state_next;

    logic [31:0]                a, b;
    logic                       a_s, b_s, z_s;
    logic signed [EXP_W-1:0]    a_e, b_e, z_e;
    logic [EXT_W-1:0]           a_m, b_m;
    logic [EXT_W:0]             sum;
    logic [MANT_W-1:0]          z_m;
    logic                       guard, round_bit, sticky;
    logic [4:0]                 align_cnt;

    logic                       a_ack_next, b_ack_next, z_stb_next, z_load;
    logic [31:0]                z_value, special_z, packed_z;
    logic                       is_special;
    logic                       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [EXP_W-1:0]    z_bexp;

    function automatic logic [EXT_W-1:0] shr_sticky(input logic [EXT_W-1:0] m);
        return {1'b0, m[EXT_W-1:2], m[1] | m[0]};
    endfunction

    function automatic logic round_up(input logic g, input logic r, input logic s, input logic lsb);
        return g && (r || s || lsb);
    endfunction

    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_zero = (a[30:0] == 31'd0);
    assign b_zero = (b[30:0] == 31'd0);

    always_comb begin
        is_special = 1'b1;
        special_z  = QNAN;
        if (a_nan || b_nan)
            special_z = QNAN;
        else if (a_inf && b_inf && (a[31] != b[31]))
            special_z = QNAN;
        else if (a_inf)
            special_z = a;
        else if (b_inf)
            special_z = b;
        else if (a_zero && b_zero)
            special_z = {a[31] & b[31], 31'd0};
        else if (a_zero)
            special_z = b;
        else if (b_zero)
            special_z = a;
        else
            is_special = 1'b0;
    end

    // A zero mantissa after normalisation only arises from exact cancellation.
    assign z_bexp = z_e + BIAS;

    always_comb begin
        if (z_m == '0)
            packed_z = 32'd0;
        else if (z_bexp >= 10'sd255)
            packed_z = {z_s, 8'hFF, 23'd0};
        else if ((z_e == EMIN) && !z_m[MANT_W-1])
            packed_z = {z_s, 8'h00, z_m[22:0]};
        else
            packed_z = {z_s, z_bexp[7:0], z_m[22:0]};
    end

    always_comb begin
        state_next = state;
        a_ack_next = 1'b0;
        b_ack_next = 1'b0;
        z_stb_next = 1'b0;
        z_load     = 1'b0;
        z_value    = packed_z;
        case (state)
            GET_A: begin
                a_ack_next = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    a_ack_next = 1'b0;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                b_ack_next = 1'b1;
                if (input_b_ack && input_b_stb) begin
                    b_ack_next = 1'b0;
                    state_next = UNPACK;
                end
            end
            UNPACK:  state_next = SPECIAL;
            SPECIAL: begin
                if (is_special) begin
                    z_load     = 1'b1;
                    z_value    = special_z;
                    state_next = PUT_Z;
                end else begin
                    state_next = ALIGN;
                end
            end
            ALIGN:   state_next = (a_e == b_e) ? ADD_0 : ALIGN;
            ADD_0:   state_next = ADD_1;
            ADD_1:   state_next = NORM_1;
            NORM_1: begin
                if ({z_m, guard, round_bit, sticky} == '0)
                    state_next = ROUND;
                else if (!z_m[MANT_W-1] && (z_e > EMIN))
                    state_next = NORM_1;
                else
                    state_next = NORM_2;
            end
            NORM_2:  state_next = (z_e < EMIN) ? NORM_2 : ROUND;
            ROUND:   state_next = PACK;
            PACK: begin
                z_load     = 1'b1;
                state_next = PUT_Z;
            end
            PUT_Z: begin
                z_stb_next = 1'b1;
                if (output_z_stb && output_z_ack) begin
                    z_stb_next = 1'b0;
                    state_next = GET_A;
                end
            end
            default: state_next = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'd0;
        end else begin
            state        <= state_next;
            input_a_ack  <= a_ack_next;
            input_b_ack  <= b_ack_next;
            output_z_stb <= z_stb_next;
            if (z_load)
                output_z <= z_value;
        end
    end

    // Datapath registers carry no reset; every field is rewritten before use.
    always_ff @(posedge clk) begin
        case (state)
            GET_A: if (input_a_ack && input_a_stb) a <= input_a;
            GET_B: if (input_b_ack && input_b_stb) b <= input_b;
            UNPACK: begin
                a_s       <= a[31];
                b_s       <= b[31];
                a_e       <= (a[30:23] == 8'd0) ? EMIN : $signed({2'b00, a[30:23]}) - BIAS;
                b_e       <= (b[30:23] == 8'd0) ? EMIN : $signed({2'b00, b[30:23]}) - BIAS;
                a_m       <= {(a[30:23] != 8'd0), a[22:0], 3'b000};
                b_m       <= {(b[30:23] != 8'd0), b[22:0], 3'b000};
                align_cnt <= 5'd0;
            end
            ALIGN: begin
                // After EXT_W-1 shifts the remaining bits can only feed sticky.
                if (a_e > b_e) begin
                    if (align_cnt == 5'(EXT_W - 1)) begin
                        b_e <= a_e;
                        b_m <= {{(EXT_W-1){1'b0}}, |b_m};
                    end else begin
                        b_e <= b_e + 10'sd1;
                        b_m <= shr_sticky(b_m);
                    end
                    align_cnt <= align_cnt + 5'd1;
                end else if (b_e > a_e) begin
                    if (align_cnt == 5'(EXT_W - 1)) begin
                        a_e <= b_e;
                        a_m <= {{(EXT_W-1){1'b0}}, |a_m};
                    end else begin
                        a_e <= a_e + 10'sd1;
                        a_m <= shr_sticky(a_m);
                    end
                    align_cnt <= align_cnt + 5'd1;
                end
            end
            ADD_0: begin
                z_e <= a_e;
                if (a_s == b_s) begin
                    sum <= {1'b0, a_m} + {1'b0, b_m};
                    z_s <= a_s;
                end else if (a_m >= b_m) begin
                    sum <= {1'b0, a_m} - {1'b0, b_m};
                    z_s <= a_s;
                end else begin
                    sum <= {1'b0, b_m} - {1'b0, a_m};
                    z_s <= b_s;
                end
            end
            ADD_1: begin
                if (sum[EXT_W]) begin
                    z_m       <= sum[EXT_W:4];
                    guard     <= sum[3];
                    round_bit <= sum[2];
                    sticky    <= sum[1] | sum[0];
                    z_e       <= z_e + 10'sd1;
                end else begin
                    z_m       <= sum[EXT_W-1:3];
                    guard     <= sum[2];
                    round_bit <= sum[1];
                    sticky    <= sum[0];
                end
            end
            NORM_1: begin
                if (!z_m[MANT_W-1] && (z_e > EMIN)) begin
                    z_e       <= z_e - 10'sd1;
                    z_m       <= {z_m[MANT_W-2:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                end
            end
            NORM_2: begin
                if (z_e < EMIN) begin
                    z_e       <= z_e + 10'sd1;
                    z_m       <= {1'b0, z_m[MANT_W-1:1]};
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                end
            end
            ROUND: begin
                if (round_up(guard, round_bit, sticky, z_m[0])) begin
                    if (&z_m) begin
                        z_m <= {1'b1, {(MANT_W-1){1'b0}}};
                        z_e <= z_e + 10'sd1;
                    end else begin
                        z_m <= z_m + 24'd1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_adder.sv
// Scoreboard bench for fp_adder: expected sums are queued as operands are
// driven and compared when the result strobe appears.
module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] input_b = 32'd0;
    logic        input_b_stb = 1'b0;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        hold_ack = 1'b0;

    fp_adder dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] va[18] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000,
                            32'h3F800001, 32'h7F800000, 32'h7F7FFFFF, 32'h00000001,
                            32'h7F800001, 32'hFF800000, 32'h80000000, 32'h80000000,
                            32'h00000000, 32'h4B000000, 32'h3F800000, 32'h00800000,
                            32'h40000000, 32'h7F7FFFFF};
    logic [31:0] vb[18] = '{32'h3F800000, 32'h40100000, 32'hBF800000, 32'h33800000,
                            32'h33800000, 32'hFF800000, 32'h7F7FFFFF, 32'h00000001,
                            32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000,
                            32'hC0490FDB, 32'h3F800000, 32'hB0800000, 32'h80000001,
                            32'hBF800000, 32'h73000000};
    logic [31:0] vz[18] = '{32'h40000000, 32'h40700000, 32'h00000000, 32'h3F800000,
                            32'h3F800002, 32'h7FC00000, 32'h7F800000, 32'h00000002,
                            32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000,
                            32'hC0490FDB, 32'h4B000001, 32'h3F800000, 32'h007FFFFF,
                            32'h3F800000, 32'h7F800000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] v);
        int t = 0;
        input_a     = v;
        input_a_stb = 1'b1;
        while (input_a_ack !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check_eq("a_ack_seen", 32'(input_a_ack), 32'd1);
        tick();
        input_a_stb = 1'b0;
        input_a     = 32'hDEAD_BEEF;
        check_eq("a_ack_drop", 32'(input_a_ack), 32'd0);
    endtask

    task automatic send_b(input logic [31:0] v);
        int t = 0;
        input_b     = v;
        input_b_stb = 1'b1;
        while (input_b_ack !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check_eq("b_ack_seen", 32'(input_b_ack), 32'd1);
        tick();
        input_b_stb = 1'b0;
        input_b     = 32'hBAAD_F00D;
        check_eq("b_ack_drop", 32'(input_b_ack), 32'd0);
    endtask

    task automatic recv_z(input string tag);
        int t = 0;
        logic [31:0] want;
        while (output_z_stb !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check_eq({tag, "_stb"}, 32'(output_z_stb), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check_eq(tag, output_z, want);
        output_z_ack = 1'b1;
        tick();
        output_z_ack = hold_ack;
        check_eq({tag, "_stb_drop"}, 32'(output_z_stb), 32'd0);
        check_eq({tag, "_hold"}, output_z, want);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input string tag);
        output_z_ack = hold_ack;
        send_a(a);
        exp_q.push_back(z);
        send_b(b);
        recv_z(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_stb;

        repeat (3) tick();
        check_eq("rst_a_ack", 32'(input_a_ack), 32'd0);
        check_eq("rst_b_ack", 32'(input_b_ack), 32'd0);
        check_eq("rst_z_stb", 32'(output_z_stb), 32'd0);
        check_eq("rst_z", output_z, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("a_ack_after_rst", 32'(input_a_ack), 32'd1);

        run_op(32'h00000000, 32'h00000000, 32'h00000000, "zero_plus_zero");
        tick();
        check_eq("back_to_get_a", 32'(input_a_ack), 32'd1);

        for (int i = 0; i < 18; i++) begin
            hold_ack = (i % 4 == 3);
            run_op(va[i], vb[i], vz[i], $sformatf("vec%0d", i));
        end
        hold_ack     = 1'b0;
        output_z_ack = 1'b0;

        // Operand B withheld: the adder must sit in GET_B offering ack.
        send_a(32'h3FC00000);
        repeat (6) tick();
        check_eq("wait_b_ack", 32'(input_b_ack), 32'd1);
        check_eq("wait_b_no_stb", 32'(output_z_stb), 32'd0);
        exp_q.push_back(32'h40700000);
        send_b(32'h40100000);
        recv_z("late_b");

        // Reset during alignment of a 23-step exponent gap.
        send_a(32'h4B000000);
        send_b(32'h3F800000);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_a_ack", 32'(input_a_ack), 32'd0);
        check_eq("abort_b_ack", 32'(input_b_ack), 32'd0);
        check_eq("abort_z_stb", 32'(output_z_stb), 32'd0);
        check_eq("abort_z", output_z, 32'd0);
        seen_stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (output_z_stb === 1'b1) seen_stb = 1'b1;
        end
        check_eq("abort_no_stb", 32'(seen_stb), 32'd0);
        check_eq("abort_a_ack_back", 32'(input_a_ack), 32'd1);

        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, "after_abort");
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
